// File: rtl/div_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : div_period_meter
// Description : Measures the average period of a divided clock (sig_in) in
//               clk_in cycles. Periods are rising-edge-to-rising-edge; WIN
//               consecutive periods are summed into period_x10 (x10 average
//               when WIN=10), with min/max period of the window. Loss of
//               sig_in edges while measuring raises a one-cycle timeout_err.
// Ports       : clk_in      - system clock (same clock that drives the divider)
//               rst         - asynchronous active-high reset
//               sig_in      - divided clock under test, synchronous to clk_in
//               period_x10  - sum of the last completed window's WIN periods
//               min_per     - shortest period in the last completed window
//               max_per     - longest period in the last completed window
//               meas_valid  - one-cycle pulse when the three results update
//               timeout_err - one-cycle pulse on loss of sig_in edges
//               busy        - high while measuring
// Revision    : 1.0 - initial release
// ============================================================================
module div_period_meter #(
    parameter int WIN     = 10,
    parameter int CNT_W   = 5,
    parameter int SUM_W   = 10,
    parameter int TIMEOUT = 31
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [SUM_W-1:0] period_x10,
    output logic [CNT_W-1:0] min_per,
    output logic [CNT_W-1:0] max_per,
    output logic             meas_valid,
    output logic             timeout_err,
    output logic             busy
);

    localparam int               c_IDX_W    = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIN - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MEAS = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_sig_d;
    logic [CNT_W-1:0]   r_per_cnt;
    logic [c_IDX_W-1:0] r_per_idx;
    logic [SUM_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_min;
    logic [CNT_W-1:0]   r_max;

    logic               w_rise;
    logic [SUM_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_min_next;
    logic [CNT_W-1:0]   w_max_next;

    // sig_d resets high so a sig_in already high at reset release is not
    // mistaken for a rising edge.
    assign w_rise = sig_in & ~r_sig_d;

    // Running window statistics including the period captured this cycle.
    assign w_acc_next = r_acc + SUM_W'(r_per_cnt);
    assign w_min_next = (r_per_cnt < r_min) ? r_per_cnt : r_min;
    assign w_max_next = (r_per_cnt > r_max) ? r_per_cnt : r_max;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sig_d     <= 1'b1;
            r_per_cnt   <= '0;
            r_per_idx   <= '0;
            r_acc       <= '0;
            r_min       <= '1;
            r_max       <= '0;
            period_x10  <= '0;
            min_per     <= '0;
            max_per     <= '0;
            meas_valid  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_sig_d     <= sig_in;
            meas_valid  <= 1'b0;
            timeout_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // First edge only arms the meter; no period exists yet.
                    if (w_rise) begin
                        r_state   <= S_MEAS;
                        busy      <= 1'b1;
                        r_per_cnt <= CNT_W'(1);
                        r_per_idx <= '0;
                        r_acc     <= '0;
                        r_min     <= '1;
                        r_max     <= '0;
                    end
                end

                S_MEAS: begin
                    if (w_rise) begin
                        // Edge wins over a coincident timeout: the period is
                        // captured and this edge starts the next period.
                        r_per_cnt <= CNT_W'(1);
                        if (r_per_idx == c_IDX_LAST) begin
                            period_x10 <= w_acc_next;
                            min_per    <= w_min_next;
                            max_per    <= w_max_next;
                            meas_valid <= 1'b1;
                            r_per_idx  <= '0;
                            r_acc      <= '0;
                            r_min      <= '1;
                            r_max      <= '0;
                        end else begin
                            r_per_idx <= r_per_idx + c_IDX_W'(1);
                            r_acc     <= w_acc_next;
                            r_min     <= w_min_next;
                            r_max     <= w_max_next;
                        end
                    end else if (r_per_cnt == c_TIMEOUT) begin
                        // Lost clock: drop the partial window, keep results.
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                        busy        <= 1'b0;
                    end else if (r_per_cnt != c_CNT_MAX) begin
                        r_per_cnt <= r_per_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
